collision_detector: RTL and testbench

Pixel-domain collision detector and the producer end of the sprite controllers' `collision` input.
- Each clock it samples the per-pixel "sprite on" flags from the diver controller and the obstacle controllers.
- It counts overlapping pixels across one frame and, at frame end, decides whether a hit occurred.
- On a hit it emits a one-cycle `collision` pulse, applies a cooldown, tracks lives and asserts `game_over`.
- It sits in display_top between the sprite controllers and the game-state logic.

---
 rtl/game_pkg.sv | 19 +
 rtl/frame_overlap_acc.sv | 50 +++++
 rtl/collision_detector.sv | 105 ++++++++++
 tb/tb_collision_detector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level types and constants for the display pipeline.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REPORT,
        COOL,
        OVER
    } state_t;

    localparam int          MAX_X               = 640;
    localparam int          MAX_Y               = 480;
    localparam logic [11:0] SPRITE_BG           = 12'h6DE;
    localparam int          DEF_LIVES           = 3;
    localparam int          DEF_COOLDOWN_FRAMES = 120;
    localparam int          CNT_W               = 12;

endpackage

// File: rtl/frame_overlap_acc.sv
// Per-frame overlap accumulator: saturating pixel counter and obstacle mask.
// cnt_now includes the current pixel so the frame-end decision can use it.
module frame_overlap_acc
    import game_pkg::*;
#(
    parameter int N_OBJ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             frame_end,
    input  logic             video_on,
    input  logic             diver_on,
    input  logic [N_OBJ-1:0] obj_on,
    output logic [CNT_W-1:0] cnt_now,
    output logic [N_OBJ-1:0] frame_mask
);

    logic             ovl;
    logic [CNT_W-1:0] cnt;
    logic [N_OBJ-1:0] mask;
    logic [N_OBJ-1:0] mask_now;

    assign ovl      = video_on && diver_on && (|obj_on);
    assign cnt_now  = (ovl && cnt != '1) ? cnt + 1'b1 : cnt;
    assign mask_now = ovl ? (mask | (obj_on & {N_OBJ{diver_on}})) : mask;

    // frame_mask snapshots the completed frame so the running mask can restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            mask       <= '0;
            frame_mask <= '0;
        end else if (clr) begin
            cnt  <= '0;
            mask <= '0;
        end else if (en) begin
            if (frame_end) begin
                cnt        <= '0;
                mask       <= '0;
                frame_mask <= mask_now;
            end else begin
                cnt  <= cnt_now;
                mask <= mask_now;
            end
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Diver/obstacle collision detector: per-frame hit decision, cooldown, lives.
// Define COLLISION_DEBUG_EN to expose the last completed frame's overlap count.
module collision_detector
    import game_pkg::*;
#(
    parameter int N_OBJ           = 4,
    parameter int HIT_THRESH      = 8,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int LIVES           = DEF_LIVES,
    parameter int END_X           = MAX_X - 1,
    parameter int END_Y           = MAX_Y - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             game_active,
    input  logic             video_on,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             diver_on,
    input  logic [N_OBJ-1:0] obj_on,
    output logic             collision,
    output logic [N_OBJ-1:0] obj_hit,
    output logic [1:0]       lives,
    output logic             game_over
`ifdef COLLISION_DEBUG_EN
    ,
    output logic [CNT_W-1:0] dbg_overlap_cnt
`endif
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 2);

    state_t           state, state_nx;
    logic             frame_end;
    logic             abort;
    logic [CNT_W-1:0] cnt_now;
    logic [N_OBJ-1:0] frame_mask;
    logic [CW-1:0]    cool_cnt;

    assign frame_end = (x == 10'(END_X)) && (y == 10'(END_Y));
    // REPORT always finishes its pulse before honouring a dropped game_active.
    assign abort     = !game_active && (state != REPORT);
    assign collision = (state == REPORT);
    assign game_over = (state == OVER);

    frame_overlap_acc #(.N_OBJ(N_OBJ)) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clr        (state != SCAN),
        .en         (state == SCAN),
        .frame_end  (frame_end),
        .video_on   (video_on),
        .diver_on   (diver_on),
        .obj_on     (obj_on),
        .cnt_now    (cnt_now),
        .frame_mask (frame_mask)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (game_active) state_nx = SCAN;
            SCAN:   if (frame_end && cnt_now >= CNT_W'(HIT_THRESH)) state_nx = REPORT;
            REPORT: begin
                if (!game_active)          state_nx = IDLE;
                else if (lives <= 2'd1)    state_nx = OVER;
                else if (COOLDOWN_FRAMES == 0) state_nx = SCAN;
                else                       state_nx = COOL;
            end
            COOL:   if (frame_end && cool_cnt <= CW'(1)) state_nx = SCAN;
            OVER:   state_nx = OVER;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lives    <= 2'(LIVES);
            obj_hit  <= '0;
            cool_cnt <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                lives   <= 2'(LIVES);
                obj_hit <= '0;
            end else if (state == REPORT) begin
                obj_hit  <= frame_mask;
                cool_cnt <= CW'(COOLDOWN_FRAMES);
                if (lives != 2'd0) lives <= lives - 2'd1;
            end else if (state == COOL && frame_end && cool_cnt != '0) begin
                cool_cnt <= cool_cnt - 1'b1;
            end
        end
    end

`ifdef COLLISION_DEBUG_EN
    always_ff @(posedge clk) begin
        if (reset)                         dbg_overlap_cnt <= '0;
        else if (state == SCAN && frame_end) dbg_overlap_cnt <= cnt_now;
    end
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Randomized frame-level bench for collision_detector on a shrunken 16x8 frame.
module tb_collision_detector;

    localparam int NO  = 4;
    localparam int TH  = 8;
    localparam int CD  = 3;
    localparam int LV  = 3;
    localparam int EX  = 15;
    localparam int EY  = 7;
    localparam int W   = EX + 1;
    localparam int PIX = W * (EY + 1);

    localparam int P_IDLE = 0, P_SCAN = 1, P_COOL = 2, P_OVER = 3;

    logic          clk = 1'b0;
    logic          reset, game_active, video_on, diver_on;
    logic [9:0]    x, y;
    logic [NO-1:0] obj_on;
    logic          collision;
    logic [NO-1:0] obj_hit;
    logic [1:0]    lives;
    logic          game_over;
`ifdef COLLISION_DEBUG_EN
    logic [11:0]   dbg_overlap_cnt;
`endif

    collision_detector #(
        .N_OBJ(NO), .HIT_THRESH(TH), .COOLDOWN_FRAMES(CD), .LIVES(LV),
        .END_X(EX), .END_Y(EY)
    ) dut (
        .clk(clk), .reset(reset), .game_active(game_active), .video_on(video_on),
        .x(x), .y(y), .diver_on(diver_on), .obj_on(obj_on),
        .collision(collision), .obj_hit(obj_hit), .lives(lives), .game_over(game_over)
`ifdef COLLISION_DEBUG_EN
        , .dbg_overlap_cnt(dbg_overlap_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference state
    int       m_phase, m_lives, m_cc, m_dbg;
    logic [3:0] m_hit;
    bit       pend;

    logic       f_div [PIX];
    logic       f_vid [PIX];
    logic [3:0] f_obj [PIX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_ovl(input int p);
        return f_vid[p] && f_div[p] && (f_obj[p] != 4'd0);
    endfunction

    task automatic check_status();
        chk("lives", 32'(lives), 32'(m_lives));
        chk("obj_hit", 32'(obj_hit), 32'(m_hit));
        chk("game_over", 32'(game_over), 32'(m_phase == P_OVER));
`ifdef COLLISION_DEBUG_EN
        chk("dbg_cnt", 32'(dbg_overlap_cnt), 32'(m_dbg));
`endif
    endtask

    task automatic start_game();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("collision_ga", 32'(collision), 32'(k == 0 && pend));
            if (k == 3) begin
                m_lives = LV;
                m_hit   = '0;
                m_phase = P_IDLE;
                check_status();
            end
            game_active = (k == 3);
            x = 10'd0; y = 10'd0;
            diver_on = 1'($urandom); obj_on = 4'($urandom); video_on = 1'($urandom);
        end
        pend    = 0;
        m_phase = P_SCAN;
    endtask

    // n placed overlaps using subsets of mask m; endp adds one on the frame-end
    // pixel; rst_at >= 0 pulses reset at that pixel with overlaps only before it.
    task automatic run_frame(input int n, input logic [3:0] m, input bit endp, input int rst_at);
        int cnt;
        int p;
        int hi;
        logic [3:0] fm;
        logic [3:0] sub;
        for (int q = 0; q < PIX; q++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                f_div[q] = 1; f_obj[q] = 4'd0; f_vid[q] = 1;
            end else if (r == 1) begin
                f_div[q] = 1; f_obj[q] = 4'($urandom_range(1, 15)); f_vid[q] = 0;
            end else begin
                f_div[q] = 0; f_obj[q] = 4'($urandom); f_vid[q] = 1;
            end
        end
        hi = (rst_at >= 0) ? rst_at - 1 : PIX - 2;
        for (int k = 0; k < n; k++) begin
            do p = $urandom_range(1, hi); while (is_ovl(p));
            sub = 4'($urandom) & m;
            if (sub == 4'd0) sub = m;
            f_div[p] = 1; f_vid[p] = 1; f_obj[p] = sub;
        end
        if (endp) begin
            f_div[PIX-1] = 1; f_vid[PIX-1] = 1; f_obj[PIX-1] = m;
        end

        for (int q = 0; q < PIX; q++) begin
            @(negedge clk);
            chk("collision", 32'(collision), 32'(q == 0 && pend));
            if (q == 1) check_status();
            x = 10'(q % W); y = 10'(q / W);
            diver_on = f_div[q]; obj_on = f_obj[q]; video_on = f_vid[q];
            reset = (q == rst_at);
        end

        pend = 0;
        if (rst_at >= 0) begin
            m_lives = LV; m_hit = '0; m_phase = P_SCAN; m_cc = 0; m_dbg = 0;
        end
        cnt = 0; fm = '0;
        for (int q = rst_at + 1; q < PIX; q++)
            if (is_ovl(q)) begin
                cnt++;
                fm |= f_obj[q];
            end
        if (cnt > 4095) cnt = 4095;
        case (m_phase)
            P_SCAN: begin
                m_dbg = cnt;
                if (cnt >= TH) begin
                    pend  = 1;
                    m_hit = fm;
                    if (m_lives > 0) m_lives--;
                    if (m_lives == 0)  m_phase = P_OVER;
                    else if (CD == 0)  m_phase = P_SCAN;
                    else begin m_phase = P_COOL; m_cc = CD; end
                end
            end
            P_COOL: if (m_cc <= 1) m_phase = P_SCAN; else m_cc--;
            default: ;
        endcase
    endtask

    initial begin
        reset = 1; game_active = 0; video_on = 0; diver_on = 0;
        obj_on = '0; x = '0; y = '0;
        m_phase = P_IDLE; m_lives = LV; m_cc = 0; m_dbg = 0; m_hit = '0; pend = 0;
        repeat (3) @(negedge clk);
        chk("rst_collision", 32'(collision), 32'd0);
        check_status();
        reset = 0;

        start_game();
        run_frame(10, 4'b0010, 0, -1);
        for (int k = 0; k < 3; k++) run_frame(12, 4'($urandom_range(1, 15)), 0, -1);
        run_frame(7, 4'b0100, 0, -1);
        run_frame(3, 4'b0001, 0, -1);
        for (int k = 0; k < 8; k++) run_frame(9, 4'($urandom_range(1, 15)), 0, -1);
        start_game();
        run_frame(7, 4'b1001, 1, -1);
        for (int k = 0; k < 3; k++) run_frame(0, 4'b0001, 0, -1);
        run_frame(5, 4'b0110, 0, 7);
        run_frame(3, 4'b0110, 0, -1);
        run_frame(0, 4'b0001, 0, -1);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0) start_game();
            run_frame($urandom_range(0, 14), 4'($urandom_range(1, 15)), 1'($urandom), -1);
        end
        run_frame(0, 4'b0001, 0, -1);
        run_frame(0, 4'b0001, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
